// File: rtl/hqc_rsdecod_seq_if.sv
// hqc_rsdecod_seq_if: start/done handshakes between the RS decode sequencer and its stages.
interface hqc_rsdecod_seq_if;
  logic stage_clr_o;
  logic syn_start_o;
  logic syn_done_i;
  logic syn_zero_i;
  logic bm_start_o;
  logic bm_done_i;
  logic roots_start_o;
  logic roots_valid_i;
  logic ev_start_o;
  logic ev_done_i;
  logic corr_start_o;
  logic corr_done_i;
  modport master (
    output stage_clr_o, syn_start_o, bm_start_o, roots_start_o, ev_start_o, corr_start_o,
    input  syn_done_i, syn_zero_i, bm_done_i, roots_valid_i, ev_done_i, corr_done_i
  );
  modport slave (
    input  stage_clr_o, syn_start_o, bm_start_o, roots_start_o, ev_start_o, corr_start_o,
    output syn_done_i, syn_zero_i, bm_done_i, roots_valid_i, ev_done_i, corr_done_i
  );
endinterface

// File: rtl/hqc_rsdecod_seq.sv
// hqc_rsdecod_seq: sequences the HQC Reed-Solomon decode stages SYN->BM->ROOTS->EV->CORR
// with per-stage timeout, abort, and a saturating total-cycle counter.
module hqc_rsdecod_seq #(
  parameter int PARAM_SECURITY = 128,
  parameter int TIMEOUT_CYC    = 4096,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [2:0]       stage_o,
  output logic [CNT_W-1:0] cycles_o,
  hqc_rsdecod_seq_if.master stg
);
  typedef enum logic [2:0] {IDLE, SYN, BM, ROOTS, EV, CORR, DONE, ERR} state_t;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1 + 0 * PARAM_SECURITY);
  state_t           state_q, state_d;
  logic [5:1]       strt_q, strt_d;
  logic [CNT_W-1:0] stg_cnt_q, stg_cnt_d, cycles_q, cycles_d;
  logic             error_q, error_d;
  logic             acc, cmp, tmo, in_stg;
  logic [7:0]       dn;
  // Done inputs indexed by the state that owns them; non-stage states see 0.
  assign dn = {2'b0, stg.corr_done_i, stg.ev_done_i, stg.roots_valid_i, stg.bm_done_i,
               stg.syn_done_i, 1'b0};
  assign busy_o  = state_q inside {SYN, BM, ROOTS, EV, CORR, DONE};
  assign done_o  = state_q == DONE;
  assign error_o = error_q;
  assign stage_o = state_q;
  assign cycles_o = cycles_q;
  assign stg.stage_clr_o   = acc && !abort_i && rst_ni;
  assign stg.syn_start_o   = strt_q[1];
  assign stg.bm_start_o    = strt_q[2];
  assign stg.roots_start_o = strt_q[3];
  assign stg.ev_start_o    = strt_q[4];
  assign stg.corr_start_o  = strt_q[5];
  always_comb begin
    in_stg  = state_q inside {SYN, BM, ROOTS, EV, CORR};
    acc     = (state_q == IDLE || state_q == ERR) && start_i;
    cmp     = dn[state_q] && !(|strt_q);
    tmo     = in_stg && stg_cnt_q == TMO_LAST && !cmp;
    state_d = state_q;
    error_d = error_q;
    if (abort_i) begin
      state_d = IDLE;
      error_d = 1'b0;
    end else if (acc) begin
      state_d = SYN;
      error_d = 1'b0;
    end else if (cmp) begin
      state_d = (state_q == SYN && stg.syn_zero_i) ? DONE : state_t'(state_q + 3'd1);
    end else if (tmo) begin
      state_d = ERR;
      error_d = 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    stg_cnt_d = (state_d != state_q) ? '0 : in_stg ? stg_cnt_q + 1'b1 : stg_cnt_q;
    cycles_d  = (acc && !abort_i) ? '0 : (busy_o && cycles_q != '1) ? cycles_q + 1'b1 : cycles_q;
    strt_d    = '0;
    for (int i = 1; i < 6; i++) strt_d[i] = state_d == state_t'(i) && state_q != state_t'(i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      strt_q    <= '0;
      stg_cnt_q <= '0;
      cycles_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      strt_q    <= strt_d;
      stg_cnt_q <= stg_cnt_d;
      cycles_q  <= cycles_d;
      error_q   <= error_d;
    end
  end
endmodule
